// File: rtl/psum_accum_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | psum_accum_ctrl: self-sequencing OFIFO -> psum SRAM accumulate engine     |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module psum_accum_ctrl #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int ADDR_BW = 11,
  parameter int LEN_BW  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_BW-1:0]        cfg_len,
  input  logic [ADDR_BW-1:0]       cfg_rd_base,
  input  logic [ADDR_BW-1:0]       cfg_wr_base,
  input  logic                     cfg_acc,
  input  logic                     cfg_relu,
  input  logic                     ofifo_valid,
  input  logic [COL*PSUM_BW-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  output logic                     CEN_pmem,
  output logic                     WEN_pmem,
  output logic [ADDR_BW-1:0]       A_pmem,
  output logic [COL*PSUM_BW-1:0]   D_pmem,
  input  logic [COL*PSUM_BW-1:0]   Q_pmem,
  output logic                     busy,
  output logic                     done
);

  localparam int VW = COL * PSUM_BW;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_POP  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [LEN_BW-1:0]  idx_q, len_q;
  logic [ADDR_BW-1:0] rd_base_q, wr_base_q;
  logic               acc_q, relu_q;
  logic [VW-1:0]      psum_q, res_q;
  logic [VW-1:0]      w_res;
  logic               w_last;
  logic [ADDR_BW-1:0] w_idx_a;

  assign w_last  = (idx_q == len_q - LEN_BW'(1));
  assign w_idx_a = ADDR_BW'(idx_q);

  // Per-lane add at PSUM_BW+1 bits, clamp on sign disagreement, then ReLU.
  for (genvar k = 0; k < COL; k++) begin : g_lane
    logic [PSUM_BW-1:0] w_a, w_b, w_sat;
    logic [PSUM_BW:0]   w_sum;

    assign w_a   = acc_q ? psum_q[k*PSUM_BW +: PSUM_BW] : '0;
    assign w_b   = ofifo_out[k*PSUM_BW +: PSUM_BW];
    assign w_sum = {w_a[PSUM_BW-1], w_a} + {w_b[PSUM_BW-1], w_b};

    always_comb begin
      if (w_sum[PSUM_BW] != w_sum[PSUM_BW-1])
        w_sat = w_sum[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
      else
        w_sat = w_sum[PSUM_BW-1:0];
      if (relu_q && w_sat[PSUM_BW-1])
        w_sat = '0;
    end

    assign w_res[k*PSUM_BW +: PSUM_BW] = w_sat;
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) begin
        if (cfg_len == '0) state_d = S_DONE;
        else               state_d = cfg_acc ? S_RD : S_POP;
      end
      S_RD:   state_d = S_CAP;
      S_CAP:  state_d = S_POP;
      S_POP:  if (ofifo_valid) state_d = S_WR;
      S_WR:   state_d = w_last ? S_DONE : (acc_q ? S_RD : S_POP);
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    CEN_pmem = 1'b1;
    WEN_pmem = 1'b1;
    A_pmem   = '0;
    D_pmem   = '0;
    ofifo_rd = 1'b0;
    busy     = (state_q != S_IDLE);
    done     = 1'b0;
    case (state_q)
      S_RD: begin
        CEN_pmem = 1'b0;
        A_pmem   = rd_base_q + w_idx_a;
      end
      S_POP:  ofifo_rd = ofifo_valid;
      S_WR: begin
        CEN_pmem = 1'b0;
        WEN_pmem = 1'b0;
        A_pmem   = wr_base_q + w_idx_a;
        D_pmem   = res_q;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q     <= '0;
      len_q     <= '0;
      rd_base_q <= '0;
      wr_base_q <= '0;
      acc_q     <= 1'b0;
      relu_q    <= 1'b0;
      psum_q    <= '0;
      res_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          len_q     <= cfg_len;
          rd_base_q <= cfg_rd_base;
          wr_base_q <= cfg_wr_base;
          acc_q     <= cfg_acc;
          relu_q    <= cfg_relu;
          idx_q     <= '0;
        end
        S_CAP: psum_q <= Q_pmem;
        S_POP: if (ofifo_valid) res_q <= w_res;
        S_WR:  if (!w_last) idx_q <= idx_q + LEN_BW'(1);
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
